// File: rtl/digseg_mux_ctrl.sv
// digseg_mux_ctrl: time-multiplexed seven-segment display controller.
// One 8-bit control register per digit is reachable over a ce/we/ack
// peripheral bus. Digits are scanned round-robin, SCAN_DIV clocks per slot.
// The first cycle of every slot is a guard cycle with all anodes off.
// The guard cycle prevents ghosting when the anode changes.
module digseg_mux_ctrl #(
    parameter int ADDR_W        = 2,
    parameter int SCAN_DIV      = 50000,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce_i,
    input  logic                   we_i,
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic [7:0]             data_i,
    output logic [7:0]             data_o,
    output logic                   ack_o,
    output logic [6:0]             seg_o,
    output logic                   dp_o,
    output logic [2**ADDR_W-1:0]   an_o
);

    localparam int DIGITS = 2**ADDR_W;
    localparam int PW     = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // Hex digit to segment pattern {a,b,c,d,e,f,g}
    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1110011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            4'hF:    s = 7'b1000111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    logic [7:0]        r_regs [DIGITS];
    logic              r_ack;
    logic [7:0]        r_data;
    logic [PW-1:0]     r_presc;
    logic [ADDR_W-1:0] r_scan_idx;
    logic [6:0]        r_seg;
    logic              r_dp;
    logic [DIGITS-1:0] r_an;

    logic              w_accept;
    logic [7:0]        w_cur;
    logic [DIGITS-1:0] w_an_onehot;
    logic [DIGITS-1:0] w_an_act;
    logic [6:0]        w_seg_nxt;
    logic              w_dp_nxt;
    logic [DIGITS-1:0] w_an_nxt;

    // A new access is taken only while no acknowledge is outstanding
    assign w_accept    = ce_i & ~r_ack;
    assign w_cur       = r_regs[r_scan_idx];
    assign w_an_onehot = DIGITS'(1) << r_scan_idx;

    // Bus side: register writes, read data capture and one-cycle ack
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                r_regs[i] <= 8'h00;
            end
            r_ack  <= 1'b0;
            r_data <= 8'h00;
        end else begin
            r_ack <= w_accept;
            if (w_accept && we_i) begin
                r_regs[addr_i] <= data_i;
            end
            if (w_accept && !we_i) begin
                r_data <= r_regs[addr_i];
            end
        end
    end

    // Slot prescaler and round-robin digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc    <= '0;
            r_scan_idx <= '0;
        end else if (r_presc == PRESC_LAST) begin
            r_presc    <= '0;
            r_scan_idx <= r_scan_idx + ADDR_W'(1);
        end else begin
            r_presc    <= r_presc + PW'(1);
        end
    end

    // Next display drive from the current slot position and digit register
    always_comb begin
        w_seg_nxt = 7'b0000000;
        w_dp_nxt  = 1'b0;
        w_an_act  = '0;
        if (r_presc == '0) begin
            // guard cycle: everything dark while the anode switches
            w_an_act = '0;
        end else if (w_cur[7]) begin
            w_seg_nxt = w_cur[6:0];
            w_an_act  = w_an_onehot;
        end else if (w_cur[5]) begin
            // blanked hex digit keeps its anode off for the whole slot
            w_an_act = '0;
        end else begin
            w_seg_nxt = hex_decode(w_cur[3:0]);
            w_dp_nxt  = w_cur[4];
            w_an_act  = w_an_onehot;
        end
    end

    // Apply anode polarity
    always_comb begin
        if (AN_ACTIVE_LOW) begin
            w_an_nxt = ~w_an_act;
        end else begin
            w_an_nxt = w_an_act;
        end
    end

    // Registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= 7'b0000000;
            r_dp  <= 1'b0;
            r_an  <= AN_OFF;
        end else begin
            r_seg <= w_seg_nxt;
            r_dp  <= w_dp_nxt;
            r_an  <= w_an_nxt;
        end
    end

    assign data_o = r_data;
    assign ack_o  = r_ack;
    assign seg_o  = r_seg;
    assign dp_o   = r_dp;
    assign an_o   = r_an;

endmodule
